// File: rtl/arith_div_pkg.sv
// Shared types and sign helpers for the iterative divider.
// Helpers work on a wide container; callers sign-extend and slice back to WIDTH.
package arith_div_pkg;

  localparam int DIV_MAX_W = 128;
  localparam logic [DIV_MAX_W-1:0] DIV_ONE = {{(DIV_MAX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                    input logic neg);
    logic [DIV_MAX_W-1:0] res;
    if (neg) begin
      res = (~x) + DIV_ONE;
    end else begin
      res = x;
    end
    return res;
  endfunction

  // Input must already be sign-extended to DIV_MAX_W when is_signed is set.
  function automatic logic [DIV_MAX_W-1:0] abs_mag(input logic [DIV_MAX_W-1:0] x,
                                                   input logic is_signed);
    return cond_neg(x, is_signed & x[DIV_MAX_W-1]);
  endfunction

endpackage

// File: rtl/arith_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract,
// and set the new quotient LSB.
module arith_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // True difference is below divisor, so WIDTH-bit modulo subtraction is exact.
  assign shifted_s = {rem_in, quo_in[WIDTH-1]};
  assign diff_s    = shifted_s[WIDTH-1:0] - divisor;
  assign ge_s      = (shifted_s >= {1'b0, divisor});

  // Restore or keep the trial subtraction.
  always_comb begin
    rem_out = shifted_s[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (ge_s) begin
      rem_out = diff_s;
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/arith_div_iter.sv
// Iterative restoring divider behind a valid/ready handshake, one quotient bit per clock.
// Define ARITH_DIV_BYPASS_EN to finish divide-by-zero and |a|<|b| ops without iterating.
module arith_div_iter
  import arith_div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data,
  output logic [WIDTH-1:0] rem_data,
  output logic             result_dz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [DIV_MAX_W-WIDTH-1:0] EXT_ZERO = {(DIV_MAX_W-WIDTH){1'b0}};

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] rem_r, quo_r, div_r, a_raw_r;
  logic             q_neg_r, r_neg_r, dz_r;
  logic             result_valid_r, result_dz_r;
  logic [WIDTH-1:0] result_data_r, rem_data_r;

  logic                 fire_s, bypass_s, dz_in_s, a_sign_s, b_sign_s;
  logic [DIV_MAX_W-1:0] a_ext_s, b_ext_s, abs_a_full_s, abs_b_full_s;
  logic [DIV_MAX_W-1:0] q_fix_full_s, r_fix_full_s;
  logic [WIDTH-1:0]     abs_a_s, abs_b_s, rem_nxt_s, quo_nxt_s, q_fix_s, r_fix_s;
  logic                 fold_unused_s;

  assign fire_s   = (state_r == IDLE) & a_valid & b_valid;
  assign a_ready  = fire_s;
  assign b_ready  = fire_s;
  assign dz_in_s  = (b_data == ALL_ZERO);
  assign a_sign_s = SIGNED & a_data[WIDTH-1];
  assign b_sign_s = SIGNED & b_data[WIDTH-1];

  assign a_ext_s      = {{(DIV_MAX_W-WIDTH){a_sign_s}}, a_data};
  assign b_ext_s      = {{(DIV_MAX_W-WIDTH){b_sign_s}}, b_data};
  assign abs_a_full_s = abs_mag(a_ext_s, SIGNED);
  assign abs_b_full_s = abs_mag(b_ext_s, SIGNED);
  assign abs_a_s      = abs_a_full_s[WIDTH-1:0];
  assign abs_b_s      = abs_b_full_s[WIDTH-1:0];

`ifdef ARITH_DIV_BYPASS_EN
  assign bypass_s = dz_in_s | (abs_a_s < abs_b_s);
`else
  assign bypass_s = 1'b0;
`endif

  arith_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (div_r),
    .rem_out (rem_nxt_s),
    .quo_out (quo_nxt_s)
  );

  // Fix-up applies to the final iteration's outputs so results land with the DONE transition.
  assign q_fix_full_s = cond_neg({EXT_ZERO, quo_nxt_s}, q_neg_r);
  assign r_fix_full_s = cond_neg({EXT_ZERO, rem_nxt_s}, r_neg_r);
  assign q_fix_s      = q_fix_full_s[WIDTH-1:0];
  assign r_fix_s      = r_fix_full_s[WIDTH-1:0];

  assign fold_unused_s = ^{abs_a_full_s[DIV_MAX_W-1:WIDTH], abs_b_full_s[DIV_MAX_W-1:WIDTH],
                           q_fix_full_s[DIV_MAX_W-1:WIDTH], r_fix_full_s[DIV_MAX_W-1:WIDTH]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          if (bypass_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (count_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r        <= {CNT_W{1'b0}};
      rem_r          <= ALL_ZERO;
      quo_r          <= ALL_ZERO;
      div_r          <= ALL_ZERO;
      a_raw_r        <= ALL_ZERO;
      q_neg_r        <= 1'b0;
      r_neg_r        <= 1'b0;
      dz_r           <= 1'b0;
      result_valid_r <= 1'b0;
      result_dz_r    <= 1'b0;
      result_data_r  <= ALL_ZERO;
      rem_data_r     <= ALL_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            count_r <= {CNT_W{1'b0}};
            rem_r   <= ALL_ZERO;
            quo_r   <= abs_a_s;
            div_r   <= abs_b_s;
            a_raw_r <= a_data;
            q_neg_r <= a_sign_s ^ b_sign_s;
            r_neg_r <= a_sign_s;
            dz_r    <= dz_in_s;
            if (bypass_s) begin
              result_valid_r <= 1'b1;
              result_dz_r    <= dz_in_s;
              result_data_r  <= dz_in_s ? ALL_ONES : ALL_ZERO;
              rem_data_r     <= a_data;
            end
          end
        end
        BUSY: begin
          rem_r   <= rem_nxt_s;
          quo_r   <= quo_nxt_s;
          count_r <= count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            result_valid_r <= 1'b1;
            result_dz_r    <= dz_r;
            result_data_r  <= dz_r ? ALL_ONES : q_fix_s;
            rem_data_r     <= dz_r ? a_raw_r : r_fix_s;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_r <= 1'b0;
          end
        end
        default: begin
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid = result_valid_r;
  assign result_dz    = result_dz_r;
  assign result_data  = result_data_r;
  assign rem_data     = rem_data_r;

endmodule

// File: tb/tb_arith_div_iter.sv
// Self-checking bench for arith_div_iter (WIDTH=8), signed and unsigned instances
// sharing stimulus; sel_u steers the handshake to one instance at a time.
module tb_arith_div_iter;

  localparam int W = 8;
  localparam int FULL_LAT = W + 1;
`ifdef ARITH_DIV_BYPASS_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic rst, a_valid, b_valid, result_ready, sel_u;
  logic [W-1:0] a_data, b_data;

  logic s_a_valid, s_b_valid, s_a_ready, s_b_ready, s_valid, s_dz;
  logic u_a_valid, u_b_valid, u_a_ready, u_b_ready, u_valid, u_dz;
  logic [W-1:0] s_q, s_r, u_q, u_r;
  logic o_a_ready, o_b_ready, o_valid, o_dz;
  logic [W-1:0] o_q, o_r;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign s_a_valid = a_valid & ~sel_u;
  assign s_b_valid = b_valid & ~sel_u;
  assign u_a_valid = a_valid & sel_u;
  assign u_b_valid = b_valid & sel_u;
  assign o_a_ready = sel_u ? u_a_ready : s_a_ready;
  assign o_b_ready = sel_u ? u_b_ready : s_b_ready;
  assign o_valid   = sel_u ? u_valid : s_valid;
  assign o_dz      = sel_u ? u_dz : s_dz;
  assign o_q       = sel_u ? u_q : s_q;
  assign o_r       = sel_u ? u_r : s_r;

  arith_div_iter #(.WIDTH(W), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(s_a_valid), .a_ready(s_a_ready), .a_data(a_data),
    .b_valid(s_b_valid), .b_ready(s_b_ready), .b_data(b_data),
    .result_valid(s_valid), .result_ready(result_ready),
    .result_data(s_q), .rem_data(s_r), .result_dz(s_dz)
  );

  arith_div_iter #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst),
    .a_valid(u_a_valid), .a_ready(u_a_ready), .a_data(a_data),
    .b_valid(u_b_valid), .b_ready(u_b_ready), .b_data(b_data),
    .result_valid(u_valid), .result_ready(result_ready),
    .result_data(u_q), .rem_data(u_r), .result_dz(u_dz)
  );

  // Reference: plain integer division (truncating), remainder takes dividend sign.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int lat);
    int ia, ib, qi, ri, ma, mb;
    if (uns) begin
      ia = int'(a);
      ib = int'(b);
    end else begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end
    ma = (ia < 0) ? -ia : ia;
    mb = (ib < 0) ? -ib : ib;
    dz = (ib == 0);
    if (dz) begin
      q = 8'hFF;
      r = a;
    end else begin
      qi = ia / ib;
      ri = ia % ib;
      q = qi[W-1:0];
      r = ri[W-1:0];
    end
    lat = (dz || ma < mb) ? SHORT_LAT : FULL_LAT;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat, input string name);
    int n;
    sel_u = uns;
    a_data = a;
    b_data = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    result_ready = 1'b1;
    #1;
    total++;
    if (o_a_ready !== 1'b1 || o_b_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s fire: a_ready=%b b_ready=%b want 1 1", name, o_a_ready, o_b_ready);
    end
    @(posedge clk);
    #1;
    n = 1;
    while (o_valid !== 1'b1 && n < 40) begin
      total++;
      if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_ready: cycle %0d a_ready=%b b_ready=%b want 0 0",
                 name, n, o_a_ready, o_b_ready);
      end
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (o_a_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s done_ready: a_ready=%b want 0", name, o_a_ready);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    total++;
    if (n != elat || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, n, o_valid, elat);
    end
    total++;
    if (o_q !== eq || o_r !== er || o_dz !== edz) begin
      bad++;
      $display("FAIL %s result a=%h b=%h: q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               name, a, b, o_q, o_r, o_dz, eq, er, edz);
    end
    @(posedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s release: result_valid=%b want 0", name, o_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    result_ready = 1'b0;
    sel_u = 1'b0;
    a_data = 8'h00;
    b_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s_valid, s_dz, s_q, s_r, s_a_ready, s_b_ready} !== 20'h0) begin
      bad++;
      $display("FAIL reset_signed: valid=%b dz=%b q=%h r=%h ar=%b br=%b want all 0",
               s_valid, s_dz, s_q, s_r, s_a_ready, s_b_ready);
    end
    total++;
    if ({u_valid, u_dz, u_q, u_r, u_a_ready, u_b_ready} !== 20'h0) begin
      bad++;
      $display("FAIL reset_unsigned: valid=%b dz=%b q=%h r=%h ar=%b br=%b want all 0",
               u_valid, u_dz, u_q, u_r, u_a_ready, u_b_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_op(8'd100, 8'd7,   1'b0, 8'h0E, 8'h02, 1'b0, FULL_LAT,  "s_100_7");
    run_op(8'h9C,  8'd7,   1'b0, 8'hF2, 8'hFE, 1'b0, FULL_LAT,  "s_m100_7");
    run_op(8'd100, 8'hF9,  1'b0, 8'hF2, 8'h02, 1'b0, FULL_LAT,  "s_100_m7");
    run_op(8'd5,   8'd0,   1'b0, 8'hFF, 8'h05, 1'b1, SHORT_LAT, "s_div0");
    run_op(8'h80,  8'hFF,  1'b0, 8'h80, 8'h00, 1'b0, FULL_LAT,  "s_overflow");
    run_op(8'd3,   8'd9,   1'b0, 8'h00, 8'h03, 1'b0, SHORT_LAT, "s_3_9");
    run_op(8'hFD,  8'd9,   1'b0, 8'h00, 8'hFD, 1'b0, SHORT_LAT, "s_m3_9");
    run_op(8'hFF,  8'h10,  1'b1, 8'h0F, 8'h0F, 1'b0, FULL_LAT,  "u_ff_10");
    run_op(8'h05,  8'h00,  1'b1, 8'hFF, 8'h05, 1'b1, SHORT_LAT, "u_div0");
    run_op(8'h80,  8'hFF,  1'b1, 8'h00, 8'h80, 1'b0, SHORT_LAT, "u_80_ff");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic edz;
    int elat;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      ref_model(a, b, (i % 3) == 2, eq, er, edz, elat);
      run_op(a, b, (i % 3) == 2, eq, er, edz, elat, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hq, hr;
    int n;
    sel_u = 1'b0;
    a_data = 8'd50;
    b_data = 8'd6;
    a_valid = 1'b1;
    b_valid = 1'b1;
    result_ready = 1'b0;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    n = 1;
    while (o_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (o_valid !== 1'b1 || o_q !== 8'd8 || o_r !== 8'd2) begin
      bad++;
      $display("FAIL bp_result: valid=%b q=%h r=%h want 1 08 02", o_valid, o_q, o_r);
    end
    hq = o_q;
    hr = o_r;
    a_data = 8'd77;
    b_data = 8'd3;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (o_valid !== 1'b1 || o_q !== hq || o_r !== hr || o_a_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d valid=%b q=%h r=%h a_ready=%b want 1 %h %h 0",
                 c, o_valid, o_q, o_r, o_a_ready, hq, hr);
      end
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: result_valid=%b want 0", o_valid);
    end
    a_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      total++;
      if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0 || o_valid !== 1'b0) begin
        bad++;
        $display("FAIL lone_valid: cycle %0d a_ready=%b b_ready=%b valid=%b want 0 0 0",
                 c, o_a_ready, o_b_ready, o_valid);
      end
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    sel_u = 1'b0;
    a_data = 8'd77;
    b_data = 8'd5;
    a_valid = 1'b1;
    b_valid = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_q !== 8'h00 || o_r !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid: valid=%b q=%h r=%h want 0 00 00", o_valid, o_q, o_r);
    end
    for (int c = 0; c < 12; c++) begin
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_abort: cycle %0d result_valid=%b want 0", c, o_valid);
      end
      @(posedge clk);
      #1;
    end
    run_op(8'd9, 8'd3, 1'b0, 8'h03, 8'h00, 1'b0, FULL_LAT, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq, er;
    logic edz;
    int elat;
    for (int i = 0; i < 4; i++) begin
      ref_model(8'd200 - W'(i), 8'd13 + W'(i), 1'b1, eq, er, edz, elat);
      run_op(8'd200 - W'(i), 8'd13 + W'(i), 1'b1, eq, er, edz, elat, "b2b_u");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
